// File: rtl/branch_update_unit.sv
// -----------------------------------------------------------------------------
// branch_update_unit
//
// This block resolves branches in the execute stage. Each time a branch is
// sampled, it does the following:
//   * It compares the actual outcome with the prediction made at fetch time.
//     On a mispredict it raises a one-cycle redirect (FlushPipeandPC/JmpAddr)
//     and increments MispredCnt.
//   * It builds an update for the prediction cache and pushes it into a
//     2-entry FIFO. The FIFO head is offered on WriteEnable/JmpInstrAddr/
//     CHJmpAddr/CB_o and is popped when WrReady is high.
//
// Ports
//   Clk, Rst             clock; synchronous active-low reset
//   EX_Valid, EX_Stall   an event is sampled when Valid=1 and Stall=0
//   EX_Taken, EX_Target  actual outcome and taken target
//   EX_InstrAddr, EX_PC  branch address and fall-through address
//   EX_PCSource, EX_Predict, EX_CB, EX_PCMatch
//                        fetch-time prediction: taken flag, target,
//                        counter, and cache hit
//   WrReady              prediction cache accepts the head entry this cycle
//   FlushPipeandPC, JmpAddr   redirect pulse and redirect address
//   WriteEnable          update queue is non-empty
//   JmpInstrAddr, CHJmpAddr, CB_o   head entry fields
//   UpdFull, Overflow    queue full; sticky flag set when an update is dropped
//   MispredCnt           wrapping count of mispredicts
// -----------------------------------------------------------------------------
module branch_update_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        EX_Valid,
    input  logic        EX_Stall,
    input  logic        EX_Taken,
    input  logic [31:0] EX_Target,
    input  logic [31:0] EX_InstrAddr,
    input  logic [31:0] EX_PC,
    input  logic        EX_PCSource,
    input  logic [31:0] EX_Predict,
    input  logic [1:0]  EX_CB,
    input  logic        EX_PCMatch,
    input  logic        WrReady,
    output logic        FlushPipeandPC,
    output logic [31:0] JmpAddr,
    output logic        WriteEnable,
    output logic [31:0] JmpInstrAddr,
    output logic [31:0] CHJmpAddr,
    output logic [1:0]  CB_o,
    output logic        UpdFull,
    output logic        Overflow,
    output logic [15:0] MispredCnt
);

    typedef struct packed {
        logic [31:0] instr_addr;
        logic [31:0] target;
        logic [1:0]  cb;
    } upd_entry_t;

    upd_entry_t mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;

    logic       sample;
    logic       pred_taken;
    logic       mispredict;
    logic [1:0] cb_next;
    logic       enq;
    logic       enq_ok;
    logic       deq;
    upd_entry_t new_entry;

    // NOTE: every signal written in this block gets a default value first.
    // This way no path leaves a signal unassigned, so no latch is inferred.
    always_comb begin
        sample     = EX_Valid && !EX_Stall;
        pred_taken = EX_PCSource && EX_PCMatch;
        mispredict = (EX_Taken != pred_taken) ||
                     (EX_Taken && pred_taken && (EX_Predict != EX_Target));

        // 2-bit saturating counter: increment on taken, decrement on not-taken.
        cb_next = EX_CB;
        if (EX_Taken) begin
            if (EX_CB != 2'b11) cb_next = EX_CB + 2'd1;
        end else begin
            if (EX_CB != 2'b00) cb_next = EX_CB - 2'd1;
        end

        // A hit refreshes the existing entry. A taken miss allocates a new
        // entry in weak-taken state. A not-taken miss leaves no trace.
        enq       = sample && (EX_PCMatch || EX_Taken);
        new_entry = '{instr_addr: EX_InstrAddr, target: EX_Target, cb: 2'b10};
        if (EX_PCMatch) begin
            new_entry.target = EX_Taken ? EX_Target : EX_Predict;
            new_entry.cb     = cb_next;
        end

        deq    = (count != 2'd0) && WrReady;
        // When the queue is full, a push is still accepted if the head leaves
        // on the same edge.
        enq_ok = enq && ((count != 2'd2) || deq);
    end

    // NOTE: sequential state uses non-blocking assignments only. This way
    // every register samples the values from before the edge.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            FlushPipeandPC <= 1'b0;
            JmpAddr        <= '0;
            MispredCnt     <= '0;
            Overflow       <= 1'b0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            count          <= 2'd0;
            // NOTE: the queue storage is reset as well, not just the
            // pointers. It is only two registers wide, and resetting it
            // makes the head outputs read as zero after reset.
            mem[0]         <= '0;
            mem[1]         <= '0;
        end else begin
            FlushPipeandPC <= sample && mispredict;
            if (sample && mispredict) begin
                JmpAddr    <= EX_Taken ? EX_Target : EX_PC;
                MispredCnt <= MispredCnt + 16'd1;
            end

            if (deq) rd_ptr <= ~rd_ptr;
            if (enq_ok) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (enq && !enq_ok) Overflow <= 1'b1;

            case ({enq_ok, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign WriteEnable  = (count != 2'd0);
    assign UpdFull      = (count == 2'd2);
    assign JmpInstrAddr = mem[rd_ptr].instr_addr;
    assign CHJmpAddr    = mem[rd_ptr].target;
    assign CB_o         = mem[rd_ptr].cb;

endmodule

// File: tb/tb_branch_update_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_update_unit
//
// This is a self-checking bench for branch_update_unit.
// * Directed scenarios compare the outputs against literal values.
// * A reference model tracks the expected update queue as a scoreboard. An
//   entry is pushed when an event is driven and popped when the DUT's head
//   is consumed. A randomized phase compares the DUT to that model on every
//   cycle.
// -----------------------------------------------------------------------------
module tb_branch_update_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        EX_Valid, EX_Stall, EX_Taken, EX_PCSource, EX_PCMatch, WrReady;
    logic [31:0] EX_Target, EX_InstrAddr, EX_PC, EX_Predict;
    logic [1:0]  EX_CB;
    logic        FlushPipeandPC, WriteEnable, UpdFull, Overflow;
    logic [31:0] JmpAddr, JmpInstrAddr, CHJmpAddr;
    logic [1:0]  CB_o;
    logic [15:0] MispredCnt;

    branch_update_unit dut (
        .Clk(Clk), .Rst(Rst),
        .EX_Valid(EX_Valid), .EX_Stall(EX_Stall), .EX_Taken(EX_Taken),
        .EX_Target(EX_Target), .EX_InstrAddr(EX_InstrAddr), .EX_PC(EX_PC),
        .EX_PCSource(EX_PCSource), .EX_Predict(EX_Predict), .EX_CB(EX_CB),
        .EX_PCMatch(EX_PCMatch), .WrReady(WrReady),
        .FlushPipeandPC(FlushPipeandPC), .JmpAddr(JmpAddr),
        .WriteEnable(WriteEnable), .JmpInstrAddr(JmpInstrAddr),
        .CHJmpAddr(CHJmpAddr), .CB_o(CB_o), .UpdFull(UpdFull),
        .Overflow(Overflow), .MispredCnt(MispredCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] target;
        logic [1:0]  cb;
    } entry_t;

    int          n_checks = 0;
    int          n_fail   = 0;

    // reference model state
    entry_t      exp_q[$];
    logic        m_flush = 1'b0;
    logic [31:0] m_jmp   = '0;
    logic [15:0] m_cnt   = '0;
    logic        m_ovf   = 1'b0;

    wire [66:0]  head_w = {WriteEnable, JmpInstrAddr, CHJmpAddr, CB_o};
    wire [50:0]  stat_w = {FlushPipeandPC, JmpAddr, MispredCnt, Overflow, UpdFull};

    function automatic logic [1:0] model_cb(input logic [1:0] cb, input logic taken);
        logic [1:0] up_tbl [4];
        logic [1:0] dn_tbl [4];
        up_tbl = '{2'b01, 2'b10, 2'b11, 2'b11};
        dn_tbl = '{2'b00, 2'b00, 2'b01, 2'b10};
        return taken ? up_tbl[cb] : dn_tbl[cb];
    endfunction

    task automatic set_event(input logic valid, input logic stall, input logic taken,
                             input logic pcsrc, input logic pcmatch, input logic [1:0] cb,
                             input logic [31:0] instr, input logic [31:0] target,
                             input logic [31:0] pc, input logic [31:0] predict);
        EX_Valid = valid;   EX_Stall = stall;     EX_Taken = taken;
        EX_PCSource = pcsrc; EX_PCMatch = pcmatch; EX_CB = cb;
        EX_InstrAddr = instr; EX_Target = target; EX_PC = pc; EX_Predict = predict;
    endtask

    task automatic idle();
        set_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0, '0);
    endtask

    // Advance one clock. Before the edge, the model is updated from the
    // inputs currently driven. Returns #1 after the edge.
    task automatic tick();
        logic   smp, eff, mp, en, dq;
        entry_t e;
        smp = EX_Valid && !EX_Stall;
        eff = EX_PCSource && EX_PCMatch;
        mp  = (EX_Taken ^ eff) || (EX_Taken && eff && (EX_Target != EX_Predict));
        en  = smp && (EX_PCMatch || EX_Taken);
        dq  = (exp_q.size() != 0) && WrReady;
        e.instr  = EX_InstrAddr;
        e.target = !EX_PCMatch ? EX_Target : (EX_Taken ? EX_Target : EX_Predict);
        e.cb     = !EX_PCMatch ? 2'b10 : model_cb(EX_CB, EX_Taken);
        if (!Rst) begin
            exp_q.delete();
            m_flush = 1'b0; m_jmp = '0; m_cnt = '0; m_ovf = 1'b0;
        end else begin
            if (dq) void'(exp_q.pop_front());
            if (en) begin
                if (exp_q.size() < 2) exp_q.push_back(e);
                else m_ovf = 1'b1;
            end
            m_flush = smp && mp;
            if (smp && mp) begin
                m_jmp = EX_Taken ? EX_Target : EX_PC;
                m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; WrReady = 1'b0; idle();
        tick();
        n_checks++;
        if ({head_w, stat_w} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got head=%h stat=%h want all zero", head_w, stat_w);
        end
        Rst = 1'b1;
    endtask

    task automatic test_hit_correct();
        logic [35:0] got;
        WrReady = 1'b1;
        set_event(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 32'h10, 32'h100, 32'h14, 32'h100);
        tick(); idle();
        got = {FlushPipeandPC, WriteEnable, CB_o, CHJmpAddr};
        n_checks++;
        if (got !== {1'b0, 1'b1, 2'b11, 32'h100}) begin
            n_fail++;
            $display("FAIL hit_correct: got %h want %h", got, {1'b0, 1'b1, 2'b11, 32'h100});
        end
        tick(); tick();
    endtask

    task automatic test_mispredict_nt();
        logic [83:0] got;
        WrReady = 1'b1;
        set_event(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 32'h40, 32'h100, 32'h44, 32'h104);
        tick(); idle();
        got = {FlushPipeandPC, JmpAddr, CB_o, CHJmpAddr, MispredCnt, WriteEnable};
        n_checks++;
        if (got !== {1'b1, 32'h44, 2'b01, 32'h104, 16'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL mispredict_nt: got %h want %h", got,
                     {1'b1, 32'h44, 2'b01, 32'h104, 16'd1, 1'b1});
        end
        tick();
        n_checks++;
        if ({FlushPipeandPC, JmpAddr} !== {1'b0, 32'h44}) begin
            n_fail++;
            $display("FAIL flush_one_cycle: got flush=%b jmp=%h want 0 00000044", FlushPipeandPC, JmpAddr);
        end
        tick();
    endtask

    task automatic test_miss_taken();
        logic [82:0] got;
        WrReady = 1'b1;
        set_event(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h80, 32'h200, 32'h84, 32'h0);
        tick(); idle();
        got = {FlushPipeandPC, JmpAddr, JmpInstrAddr, CB_o, MispredCnt};
        n_checks++;
        if (got !== {1'b1, 32'h200, 32'h80, 2'b10, 16'd2}) begin
            n_fail++;
            $display("FAIL miss_taken: got %h want %h", got, {1'b1, 32'h200, 32'h80, 2'b10, 16'd2});
        end
        tick(); tick();
    endtask

    task automatic test_target_mismatch();
        logic [82:0] got;
        WrReady = 1'b1;
        set_event(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 32'h90, 32'h300, 32'h94, 32'h304);
        tick(); idle();
        got = {FlushPipeandPC, JmpAddr, CHJmpAddr, CB_o, MispredCnt};
        n_checks++;
        if (got !== {1'b1, 32'h300, 32'h300, 2'b11, 16'd3}) begin
            n_fail++;
            $display("FAIL target_mismatch: got %h want %h", got, {1'b1, 32'h300, 32'h300, 2'b11, 16'd3});
        end
        tick(); tick();
    endtask

    task automatic test_ignored_events();
        WrReady = 1'b1;
        // not-taken miss: the prediction is not effective without a hit,
        // so this is correct and not enqueued
        set_event(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h60, 32'h600, 32'h64, 32'h600);
        tick(); idle();
        n_checks++;
        if ({FlushPipeandPC, WriteEnable, MispredCnt} !== {1'b0, 1'b0, 16'd3}) begin
            n_fail++;
            $display("FAIL miss_not_taken: got flush=%b we=%b cnt=%0d want 0 0 3",
                     FlushPipeandPC, WriteEnable, MispredCnt);
        end
        // a stalled mispredicting event must be ignored
        set_event(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 32'h70, 32'h700, 32'h74, 32'h700);
        tick(); idle();
        n_checks++;
        if ({FlushPipeandPC, WriteEnable, MispredCnt} !== {1'b0, 1'b0, 16'd3}) begin
            n_fail++;
            $display("FAIL stall_ignored: got flush=%b we=%b cnt=%0d want 0 0 3",
                     FlushPipeandPC, WriteEnable, MispredCnt);
        end
    endtask

    task automatic test_back_to_back();
        WrReady = 1'b0;
        set_event(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 32'hB0, 32'h800, 32'hB4, 32'h800);
        tick();
        EX_InstrAddr = 32'hB4;
        tick();
        // full queue, head leaves while a new entry arrives
        WrReady = 1'b1; EX_InstrAddr = 32'hB8;
        tick(); idle();
        n_checks++;
        if ({UpdFull, Overflow, JmpInstrAddr} !== {1'b1, 1'b0, 32'hB4}) begin
            n_fail++;
            $display("FAIL full_enq_deq: got full=%b ovf=%b head=%h want 1 0 000000b4",
                     UpdFull, Overflow, JmpInstrAddr);
        end
        tick();
        n_checks++;
        if ({UpdFull, WriteEnable, JmpInstrAddr} !== {1'b0, 1'b1, 32'hB8}) begin
            n_fail++;
            $display("FAIL b2b_drain: got full=%b we=%b head=%h want 0 1 000000b8",
                     UpdFull, WriteEnable, JmpInstrAddr);
        end
        tick();
    endtask

    task automatic test_overflow();
        WrReady = 1'b0;
        set_event(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 32'hA0, 32'h900, 32'hA4, 32'h900);
        tick();
        EX_InstrAddr = 32'hA4;
        tick();
        n_checks++;
        if ({UpdFull, Overflow} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_after_two: got full=%b ovf=%b want 1 0", UpdFull, Overflow);
        end
        EX_InstrAddr = 32'hA8;
        tick(); idle();
        tick();
        n_checks++;
        if ({UpdFull, Overflow, JmpInstrAddr, CB_o} !== {2'b11, 32'hA0, 2'b11}) begin
            n_fail++;
            $display("FAIL overflow_hold: got full=%b ovf=%b head=%h cb=%b want 1 1 000000a0 11",
                     UpdFull, Overflow, JmpInstrAddr, CB_o);
        end
        WrReady = 1'b1;
        tick();
        n_checks++;
        if ({UpdFull, WriteEnable, JmpInstrAddr} !== {1'b0, 1'b1, 32'hA4}) begin
            n_fail++;
            $display("FAIL overflow_drain: got full=%b we=%b head=%h want 0 1 000000a4",
                     UpdFull, WriteEnable, JmpInstrAddr);
        end
        tick();
        n_checks++;
        if ({WriteEnable, Overflow} !== 2'b01) begin
            n_fail++;
            $display("FAIL overflow_sticky: got we=%b ovf=%b want 0 1", WriteEnable, Overflow);
        end
    endtask

    task automatic test_reset_mid();
        WrReady = 1'b0;
        set_event(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'hC0, 32'h500, 32'hC4, 32'h0);
        tick();
        EX_InstrAddr = 32'hC4; EX_Target = 32'h504;
        tick();
        n_checks++;
        if ({UpdFull, MispredCnt} !== {1'b1, 16'd5}) begin
            n_fail++;
            $display("FAIL pre_reset: got full=%b cnt=%0d want 1 5", UpdFull, MispredCnt);
        end
        // reset with a mispredicting event still present: the event must vanish
        Rst = 1'b0; EX_InstrAddr = 32'hC8;
        tick();
        n_checks++;
        if ({head_w, stat_w} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got head=%h stat=%h want all zero", head_w, stat_w);
        end
        Rst = 1'b1; idle();
        tick();
        n_checks++;
        if ({head_w, stat_w} !== '0) begin
            n_fail++;
            $display("FAIL reset_discard: got head=%h stat=%h want all zero", head_w, stat_w);
        end
    endtask

    task automatic test_random();
        logic [66:0] want_head;
        logic [50:0] want_stat;
        for (int i = 0; i < 400; i++) begin
            want_stat = {m_flush, m_jmp, m_cnt, m_ovf, exp_q.size() == 2};
            n_checks++;
            if (stat_w !== want_stat) begin
                n_fail++;
                $display("FAIL rand_stat[%0d]: got %h want %h", i, stat_w, want_stat);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                if (WriteEnable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_empty[%0d]: got we=%b want 0", i, WriteEnable);
                end
            end else begin
                want_head = {1'b1, exp_q[0]};
                if (head_w !== want_head) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got %h want %h", i, head_w, want_head);
                end
            end
            Rst     = ($urandom_range(0, 99) != 0);
            WrReady = ($urandom_range(0, 2) != 0);
            set_event($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      32'h1000 + 32'($urandom_range(0, 255)) * 4,
                      32'h2000 + 32'($urandom_range(0, 3)) * 4,
                      32'h3000 + 32'($urandom_range(0, 255)) * 4,
                      32'h2000 + 32'($urandom_range(0, 3)) * 4);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_hit_correct();
        test_mispredict_nt();
        test_miss_taken();
        test_target_mismatch();
        test_ignored_events();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_update_unit.md
BRANCH_UPDATE_UNIT -- requirements
Module: branch_update_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Clk  in  1  rising-edge clock for all state.
REQ-003 Rst  in  1  synchronous active-low reset.
REQ-004 EX_Valid  in  1  resolved branch/jump present in execute this cycle.
REQ-005 EX_Stall  in  1  execute held; EX_Valid SHALL be ignored while high.
REQ-006 EX_Taken  in  1  actual outcome.
REQ-007 EX_Target  in  32  actual taken target.
REQ-008 EX_InstrAddr  in  32  address of the branch instruction.
REQ-009 EX_PC  in  32  fall-through address (instr + 4).
REQ-010 EX_PCSource  in  1  fetch-time prediction was taken.
REQ-011 EX_Predict  in  32  fetch-time predicted target.
REQ-012 EX_CB  in  2  fetch-time counter state.
REQ-013 EX_PCMatch  in  1  fetch-time prediction cache hit.
REQ-014 WrReady  in  1  prediction cache accepts a write this cycle.
REQ-015 FlushPipeandPC  out  1  one-cycle redirect/flush pulse.
REQ-016 JmpAddr  out  32  redirect address, valid with FlushPipeandPC.
REQ-017 WriteEnable  out  1  update queue head valid.
REQ-018 JmpInstrAddr  out  32  head entry branch address.
REQ-019 CHJmpAddr  out  32  head entry target.
REQ-020 CB_o  out  2  head entry new counter.
REQ-021 UpdFull  out  1  queue holds 2 entries.
REQ-022 Overflow  out  1  sticky: an update was dropped.
REQ-023 MispredCnt  out  16  mispredictions since reset.

Function
REQ-024 An event SHALL be sampled on a rising edge with EX_Valid=1 and EX_Stall=0.
REQ-025 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; the update SHALL be +1 on taken and -1 on not-taken, saturating at 11/00.
REQ-026 Effective prediction SHALL be taken iff EX_PCSource=1 and EX_PCMatch=1.
REQ-027 Mispredict SHALL be: EX_Taken differs from the effective prediction, OR both are taken and EX_Predict differs from EX_Target.
REQ-028 On a sampled mispredict, FlushPipeandPC SHALL be 1 for exactly the next cycle, with JmpAddr = EX_Target if EX_Taken, else EX_PC; otherwise FlushPipeandPC=0 and JmpAddr holds its last value.
REQ-029 On each sampled mispredict, MispredCnt SHALL increment by 1 and wrap 0xFFFF->0x0000.
REQ-030 An update SHALL be enqueued when EX_PCMatch=1 (entry: EX_InstrAddr, EX_Target if taken else EX_Predict, updated counter) or when EX_PCMatch=0 and EX_Taken=1 (allocate: EX_InstrAddr, EX_Target, CB=10); a miss that is not taken SHALL enqueue nothing.
REQ-031 The update queue SHALL be a 2-entry FIFO; the enqueued entry SHALL be visible at the head no earlier than the cycle after sampling.
REQ-032 WriteEnable SHALL equal queue non-empty; the head SHALL be dequeued on an edge with WriteEnable=1 and WrReady=1.
REQ-033 Head outputs SHALL remain stable while WriteEnable=1 and WrReady=0.
REQ-034 A simultaneous enqueue and dequeue SHALL keep the occupancy unchanged, and SHALL be accepted when full.
REQ-035 An enqueue when full with no dequeue SHALL be dropped and SHALL set Overflow, which stays set until reset.
REQ-036 Flush generation SHALL NOT depend on queue state or WrReady.

Reset
REQ-037 With Rst=0 at an edge: the queue SHALL empty, WriteEnable=0, UpdFull=0, FlushPipeandPC=0, Overflow=0, MispredCnt=0, and JmpAddr, JmpInstrAddr, CHJmpAddr = 0 and CB_o=00.
REQ-038 An event sampled while Rst=0 SHALL be discarded; reset mid-drain SHALL discard pending entries.

Verification
REQ-039 Hit, CB=10, predicted taken to 0x100, actual taken to 0x100, WrReady=1 -> no flush; next cycle WriteEnable=1, CB_o=11, CHJmpAddr=0x100.
REQ-040 Hit, CB=10, predicted taken, actual not taken, EX_PC=0x44 -> FlushPipeandPC pulse, JmpAddr=0x44, CB_o=01, MispredCnt=1.
REQ-041 Miss, taken to 0x200 at instr 0x80 -> flush with JmpAddr=0x200; entry JmpInstrAddr=0x80, CB_o=10.
REQ-042 Hit, CB=11, taken, target 0x300 vs predict 0x304 -> flush to 0x300, CB_o=11, CHJmpAddr=0x300.
REQ-043 WrReady=0; three consecutive updating events -> UpdFull=1 after two, third dropped, Overflow=1; WrReady=1 drains the first two in order.
REQ-044 Rst=0 asserted with two queued entries and MispredCnt=5 -> all outputs at reset values the next cycle.
